accel_i2c_sequencer: RTL and testbench

Sequences all I2C traffic to the ADXL345 accelerometer: on `start` it writes the 8-entry init table, then polls the six data registers (0x32–0x37) in repeated burst reads and publishes signed X/Y/Z samples. It sits above the byte-level I2C engine (the p2s/s2p shifters plus START/STOP generation) and issues one engine command at a time over a valid/ready command channel and a response channel. On a slave NACK it retries the failed transaction, up to a limit, and then flags an error.

---
 rtl/accel_i2c_pkg.sv | 46 ++++
 rtl/accel_i2c_sequencer_init_rom.sv | 24 ++
 rtl/accel_i2c_sequencer.sv | 228 ++++++++++++++++++++++
 tb/tb_accel_i2c_sequencer.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/accel_i2c_pkg.sv
// Shared types and constants for the ADXL345 I2C command sequencer.
package accel_i2c_pkg;

  localparam int unsigned INIT_LEN = 8;
  localparam int unsigned READ_LEN = 6;
  localparam int unsigned STEP_W   = 4;
  localparam int unsigned IDX_W    = $clog2(INIT_LEN);

  typedef enum logic [1:0] {
    OP_START = 2'd0,
    OP_STOP  = 2'd1,
    OP_WRITE = 2'd2,
    OP_READ  = 2'd3
  } op_e;

  // ADXL345 register map subset
  localparam logic [7:0] REG_THRESH_ACT    = 8'h24;
  localparam logic [7:0] REG_THRESH_INACT  = 8'h25;
  localparam logic [7:0] REG_TIME_INACT    = 8'h26;
  localparam logic [7:0] REG_ACT_INACT_CTL = 8'h27;
  localparam logic [7:0] REG_BW_RATE       = 8'h2C;
  localparam logic [7:0] REG_POWER_CTL     = 8'h2D;
  localparam logic [7:0] REG_DATA_FORMAT   = 8'h31;
  localparam logic [7:0] REG_DATAX0        = 8'h32;

  // Step numbers within a transaction (init: 0..4, read burst: 0..11)
  localparam logic [STEP_W-1:0] INIT_STOP_STEP = 4'd4;
  localparam logic [STEP_W-1:0] READ_RD_FIRST  = 4'd5;
  localparam logic [STEP_W-1:0] READ_RD_LAST   = 4'(READ_RD_FIRST + READ_LEN - 1);
  localparam logic [STEP_W-1:0] READ_STOP_STEP = 4'(READ_RD_LAST + 1);

  typedef struct packed {
    op_e        op;
    logic [7:0] data;
    logic       last;
  } cmd_t;

  typedef struct packed {
    logic [7:0] addr;
    logic [7:0] data;
  } init_entry_t;

  localparam cmd_t CMD_START = '{op: OP_START, data: 8'h00, last: 1'b0};
  localparam cmd_t CMD_STOP  = '{op: OP_STOP,  data: 8'h00, last: 1'b0};

endpackage

// File: rtl/accel_i2c_sequencer_init_rom.sv
// ADXL345 power-up configuration table, one (register, data) pair per index.
module accel_init_rom
  import accel_i2c_pkg::*;
(
  input  logic [IDX_W-1:0] index,
  output init_entry_t      entry_c
);

  always_comb begin
    entry_c = '{addr: REG_DATA_FORMAT, data: 8'h0B};
    case (index)
      3'd0: entry_c = '{addr: REG_DATA_FORMAT,   data: 8'h0B};
      3'd1: entry_c = '{addr: REG_BW_RATE,       data: 8'h0B};
      3'd2: entry_c = '{addr: REG_THRESH_ACT,    data: 8'h04};
      3'd3: entry_c = '{addr: REG_THRESH_INACT,  data: 8'h02};
      3'd4: entry_c = '{addr: REG_TIME_INACT,    data: 8'h02};
      3'd5: entry_c = '{addr: REG_ACT_INACT_CTL, data: 8'hFF};
      3'd6: entry_c = '{addr: REG_POWER_CTL,     data: 8'h00};
      3'd7: entry_c = '{addr: REG_POWER_CTL,     data: 8'h08};
      default: entry_c = '{addr: REG_DATA_FORMAT, data: 8'h0B};
    endcase
  end

endmodule

// File: rtl/accel_i2c_sequencer.sv
// ADXL345 sequencer: writes the init table, then polls X/Y/Z in burst reads,
// issuing one byte-engine command at a time with NACK retry.
module accel_i2c_sequencer
  import accel_i2c_pkg::*;
#(
  parameter logic [6:0]  DEV_ADDR  = 7'h53,
  parameter logic [15:0] POLL_DIV  = 16'd1000,
  parameter int unsigned MAX_RETRY = 2
)(
  input  logic        I2C_SCLK,
  input  logic        reset,
  input  logic        start,
  output logic        cmd_valid,
  output logic [1:0]  cmd_op,
  output logic [7:0]  cmd_data,
  output logic        cmd_last,
  input  logic        cmd_ready,
  input  logic        rsp_valid,
  input  logic        rsp_ack,
  input  logic [7:0]  rsp_data,
  output logic [15:0] accel_x,
  output logic [15:0] accel_y,
  output logic [15:0] accel_z,
  output logic        sample_valid,
  output logic        init_done,
  output logic        busy,
  output logic        error
);

  localparam int unsigned RETRY_W = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
  localparam logic [7:0]  ADDR_WR = {DEV_ADDR, 1'b0};
  localparam logic [7:0]  ADDR_RD = {DEV_ADDR, 1'b1};
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(INIT_LEN - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_ISSUE, S_WAIT_RSP, S_NEXT, S_ABORT_STOP, S_POLL_WAIT
  } state_e;

  state_e             state;
  logic [STEP_W-1:0]  step;
  logic [IDX_W-1:0]   init_idx;
  logic               in_init;
  logic [RETRY_W-1:0] retry_cnt;
  logic [15:0]        poll_cnt;
  logic               abort_wait;
  logic [47:0]        shadow;

  init_entry_t        rom_entry;
  cmd_t               step_cmd_c;
  logic [STEP_W-1:0]  last_step_c;
  logic [2:0]         byte_sel_c;

  accel_init_rom u_rom (
    .index   (init_idx),
    .entry_c (rom_entry)
  );

  // Command for a given step of the current transaction type
  function automatic cmd_t build_cmd(input logic init_mode, input logic [STEP_W-1:0] s,
                                     input init_entry_t ent);
    cmd_t c;
    c = CMD_STOP;
    if (init_mode) begin
      case (s)
        4'd0:    c = CMD_START;
        4'd1:    c = '{op: OP_WRITE, data: ADDR_WR,  last: 1'b0};
        4'd2:    c = '{op: OP_WRITE, data: ent.addr, last: 1'b0};
        4'd3:    c = '{op: OP_WRITE, data: ent.data, last: 1'b0};
        default: c = CMD_STOP;
      endcase
    end else begin
      case (s)
        4'd0, 4'd3: c = CMD_START;
        4'd1:       c = '{op: OP_WRITE, data: ADDR_WR,    last: 1'b0};
        4'd2:       c = '{op: OP_WRITE, data: REG_DATAX0, last: 1'b0};
        4'd4:       c = '{op: OP_WRITE, data: ADDR_RD,    last: 1'b0};
        default: begin
          if (s >= READ_RD_FIRST && s <= READ_RD_LAST)
            c = '{op: OP_READ, data: 8'h00, last: (s == READ_RD_LAST)};
          else
            c = CMD_STOP;
        end
      endcase
    end
    return c;
  endfunction

  assign step_cmd_c  = build_cmd(in_init, step + 4'd1, rom_entry);
  assign last_step_c = in_init ? INIT_STOP_STEP : READ_STOP_STEP;
  assign byte_sel_c  = 3'(step - READ_RD_FIRST);

  always_ff @(posedge I2C_SCLK) begin
    if (reset) begin
      state        <= S_IDLE;
      step         <= '0;
      init_idx     <= '0;
      in_init      <= 1'b0;
      retry_cnt    <= '0;
      poll_cnt     <= '0;
      abort_wait   <= 1'b0;
      shadow       <= '0;
      cmd_valid    <= 1'b0;
      cmd_op       <= '0;
      cmd_data     <= '0;
      cmd_last     <= 1'b0;
      accel_x      <= '0;
      accel_y      <= '0;
      accel_z      <= '0;
      sample_valid <= 1'b0;
      init_done    <= 1'b0;
      busy         <= 1'b0;
      error        <= 1'b0;
    end else begin
      sample_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            error     <= 1'b0;
            init_done <= 1'b0;
            retry_cnt <= '0;
            init_idx  <= '0;
            in_init   <= 1'b1;
            step      <= '0;
            busy      <= 1'b1;
            cmd_valid <= 1'b1;
            {cmd_op, cmd_data, cmd_last} <= CMD_START;
            state     <= S_ISSUE;
          end
        end

        S_ISSUE: begin
          if (cmd_valid && cmd_ready) begin
            cmd_valid <= 1'b0;
            state     <= S_WAIT_RSP;
          end
        end

        S_WAIT_RSP: begin
          if (rsp_valid) begin
            if (cmd_op == OP_WRITE && !rsp_ack) begin
              abort_wait <= 1'b0;
              cmd_valid  <= 1'b1;
              {cmd_op, cmd_data, cmd_last} <= CMD_STOP;
              state      <= S_ABORT_STOP;
            end else begin
              if (cmd_op == OP_READ)
                shadow[{byte_sel_c, 3'b000} +: 8] <= rsp_data;
              if (step == last_step_c) begin
                // Terminal actions land on the rsp_valid edge so flags rise one cycle later
                retry_cnt <= '0;
                step      <= '0;
                if (in_init && init_idx != LAST_IDX) begin
                  init_idx  <= init_idx + 3'd1;
                  cmd_valid <= 1'b1;
                  {cmd_op, cmd_data, cmd_last} <= CMD_START;
                  state     <= S_ISSUE;
                end else begin
                  if (in_init) begin
                    init_done <= 1'b1;
                  end else begin
                    accel_x      <= shadow[15:0];
                    accel_y      <= shadow[31:16];
                    accel_z      <= shadow[47:32];
                    sample_valid <= 1'b1;
                  end
                  in_init <= 1'b0;
                  if (POLL_DIV == 16'd0) begin
                    cmd_valid <= 1'b1;
                    {cmd_op, cmd_data, cmd_last} <= CMD_START;
                    state     <= S_ISSUE;
                  end else begin
                    poll_cnt <= POLL_DIV - 16'd1;
                    state    <= S_POLL_WAIT;
                  end
                end
              end else begin
                state <= S_NEXT;
              end
            end
          end
        end

        S_NEXT: begin
          step      <= step + 4'd1;
          cmd_valid <= 1'b1;
          {cmd_op, cmd_data, cmd_last} <= step_cmd_c;
          state     <= S_ISSUE;
        end

        S_ABORT_STOP: begin
          if (!abort_wait) begin
            if (cmd_valid && cmd_ready) begin
              cmd_valid  <= 1'b0;
              abort_wait <= 1'b1;
            end
          end else if (rsp_valid) begin
            abort_wait <= 1'b0;
            if (retry_cnt < RETRY_W'(MAX_RETRY)) begin
              retry_cnt <= retry_cnt + 1'b1;
              step      <= '0;
              cmd_valid <= 1'b1;
              {cmd_op, cmd_data, cmd_last} <= CMD_START;
              state     <= S_ISSUE;
            end else begin
              error <= 1'b1;
              busy  <= 1'b0;
              state <= S_IDLE;
            end
          end
        end

        S_POLL_WAIT: begin
          if (poll_cnt == 16'd0) begin
            step      <= '0;
            cmd_valid <= 1'b1;
            {cmd_op, cmd_data, cmd_last} <= CMD_START;
            state     <= S_ISSUE;
          end else begin
            poll_cnt <= poll_cnt - 16'd1;
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_accel_i2c_sequencer.sv
// Directed/randomized bench: a queue of expected I2C engine transactions built
// from the device's command rules drives a behavioural engine responder.
module tb_accel_i2c_sequencer;

  localparam logic [15:0] POLL_DIV  = 16'd20;
  localparam int          MAX_RETRY = 2;
  localparam int          TMO       = 200;

  localparam logic [1:0] C_START = 2'd0;
  localparam logic [1:0] C_STOP  = 2'd1;
  localparam logic [1:0] C_WRITE = 2'd2;
  localparam logic [1:0] C_READ  = 2'd3;

  logic        I2C_SCLK = 1'b0;
  logic        reset;
  logic        start;
  logic        cmd_valid;
  logic [1:0]  cmd_op;
  logic [7:0]  cmd_data;
  logic        cmd_last;
  logic        cmd_ready;
  logic        rsp_valid;
  logic        rsp_ack;
  logic [7:0]  rsp_data;
  logic [15:0] accel_x, accel_y, accel_z;
  logic        sample_valid, init_done, busy, error;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [1:0] op;
    logic [7:0] data;
    logic       last;
    logic       ack;
    logic [7:0] rdata;
  } txn_t;

  txn_t plan[$];

  logic [7:0] init_reg [8] = '{8'h31, 8'h2C, 8'h24, 8'h25, 8'h26, 8'h27, 8'h2D, 8'h2D};
  logic [7:0] init_dat [8] = '{8'h0B, 8'h0B, 8'h04, 8'h02, 8'h02, 8'hFF, 8'h00, 8'h08};

  accel_i2c_sequencer #(
    .DEV_ADDR  (7'h53),
    .POLL_DIV  (POLL_DIV),
    .MAX_RETRY (MAX_RETRY)
  ) dut (
    .I2C_SCLK     (I2C_SCLK),
    .reset        (reset),
    .start        (start),
    .cmd_valid    (cmd_valid),
    .cmd_op       (cmd_op),
    .cmd_data     (cmd_data),
    .cmd_last     (cmd_last),
    .cmd_ready    (cmd_ready),
    .rsp_valid    (rsp_valid),
    .rsp_ack      (rsp_ack),
    .rsp_data     (rsp_data),
    .accel_x      (accel_x),
    .accel_y      (accel_y),
    .accel_z      (accel_z),
    .sample_valid (sample_valid),
    .init_done    (init_done),
    .busy         (busy),
    .error        (error)
  );

  always #5 I2C_SCLK = ~I2C_SCLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic void add(input logic [1:0] op, input logic [7:0] data,
                              input logic last, input logic ack, input logic [7:0] rdata);
    txn_t t;
    t.op = op; t.data = data; t.last = last; t.ack = ack; t.rdata = rdata;
    plan.push_back(t);
  endfunction

  // A NACKed write is followed by a STOP; returns 0 when the attempt was aborted.
  function automatic bit add_write(input logic [7:0] data, input bit nack);
    add(C_WRITE, data, 1'b0, !nack, 8'h00);
    if (nack) add(C_STOP, 8'h00, 1'b0, 1'b1, 8'h00);
    return !nack;
  endfunction

  // Init entry k; write number pos (1..3) is NACKed on the first 'times' attempts.
  function automatic void plan_init(input int k, input int pos, input int times);
    logic [7:0] w [3];
    bit ok;
    w[0] = 8'hA6; w[1] = init_reg[k]; w[2] = init_dat[k];
    for (int a = 0; a <= times && a <= MAX_RETRY; a++) begin
      add(C_START, 8'h00, 1'b0, 1'b1, 8'h00);
      ok = 1'b1;
      for (int j = 1; j <= 3 && ok; j++) ok = add_write(w[j-1], a < times && j == pos);
      if (ok) begin
        add(C_STOP, 8'h00, 1'b0, 1'b1, 8'h00);
        break;
      end
    end
  endfunction

  function automatic void plan_read(input logic [7:0] b [6], input int pos, input int times);
    for (int a = 0; a <= times && a <= MAX_RETRY; a++) begin
      add(C_START, 8'h00, 1'b0, 1'b1, 8'h00);
      if (!add_write(8'hA6, a < times && pos == 1)) continue;
      if (!add_write(8'h32, a < times && pos == 2)) continue;
      add(C_START, 8'h00, 1'b0, 1'b1, 8'h00);
      if (!add_write(8'hA7, a < times && pos == 3)) continue;
      for (int i = 0; i < 6; i++) add(C_READ, 8'h00, i == 5, 1'b1, b[i]);
      add(C_STOP, 8'h00, 1'b0, 1'b1, 8'h00);
      break;
    end
  endfunction

  // Engine behaviour for one expected command; returns on the negedge after rsp_valid.
  task automatic serve_one(input txn_t t, input int hold);
    int n;
    int lat;
    n = 0;
    while (cmd_valid !== 1'b1 && n < TMO) begin
      @(negedge I2C_SCLK);
      n++;
    end
    chk("cmd_valid_seen", {31'd0, cmd_valid}, 32'd1);
    for (int h = 0; h < hold; h++) begin
      chk("bp_valid", {31'd0, cmd_valid}, 32'd1);
      chk("bp_op", {30'd0, cmd_op}, {30'd0, t.op});
      chk("bp_data", {24'd0, cmd_data}, {24'd0, t.data});
      @(negedge I2C_SCLK);
    end
    chk("cmd_op", {30'd0, cmd_op}, {30'd0, t.op});
    chk("cmd_data", {24'd0, cmd_data}, {24'd0, t.data});
    chk("cmd_last", {31'd0, cmd_last}, {31'd0, t.last});
    cmd_ready = 1'b1;
    @(negedge I2C_SCLK);
    cmd_ready = 1'b0;
    chk("valid_drop", {31'd0, cmd_valid}, 32'd0);
    lat = $urandom_range(0, 2);
    repeat (lat) @(negedge I2C_SCLK);
    chk("no_overlap", {31'd0, cmd_valid}, 32'd0);
    rsp_valid = 1'b1;
    rsp_ack   = (t.op == C_WRITE) ? t.ack : 1'($urandom);
    rsp_data  = (t.op == C_READ) ? t.rdata : 8'($urandom);
    @(negedge I2C_SCLK);
    rsp_valid = 1'b0;
    rsp_ack   = 1'($urandom);
    rsp_data  = 8'($urandom);
  endtask

  task automatic serve_n(input int count, input int bp_at);
    txn_t t;
    for (int i = 0; i < count; i++) begin
      t = plan.pop_front();
      serve_one(t, (i == bp_at) ? 10 : $urandom_range(0, 2));
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge I2C_SCLK);
    start = 1'b0;
  endtask

  // Called on the first POLL_WAIT cycle (offset n0); next START must be POLL_DIV cycles on.
  task automatic measure_poll(input int n0, input bit spurious);
    int n;
    n = n0;
    while (cmd_valid !== 1'b1 && n < int'(POLL_DIV) + 20) begin
      @(negedge I2C_SCLK);
      n++;
      rsp_valid = spurious && n == 5;
      start     = spurious && n == 7;
    end
    rsp_valid = 1'b0;
    start     = 1'b0;
    chk("poll_len", n, 32'(POLL_DIV));
    chk("poll_op", {30'd0, cmd_op}, {30'd0, C_START});
  endtask

  task automatic check_sample(input logic [7:0] b [6]);
    chk("sample_pulse", {31'd0, sample_valid}, 32'd1);
    chk("accel_x", {16'd0, accel_x}, 32'(b[1]) * 256 + 32'(b[0]));
    chk("accel_y", {16'd0, accel_y}, 32'(b[3]) * 256 + 32'(b[2]));
    chk("accel_z", {16'd0, accel_z}, 32'(b[5]) * 256 + 32'(b[4]));
    @(negedge I2C_SCLK);
    chk("sample_once", {31'd0, sample_valid}, 32'd0);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_valid"}, {31'd0, cmd_valid}, 32'd0);
    chk({tag, "_cmd"}, {21'd0, cmd_op, cmd_data, cmd_last}, 32'd0);
    chk({tag, "_accel"}, {accel_x, accel_y | accel_z}, 32'd0);
    chk({tag, "_flags"}, {28'd0, sample_valid, init_done, busy, error}, 32'd0);
  endtask

  task automatic rand_bytes(output logic [7:0] b [6]);
    for (int i = 0; i < 6; i++) b[i] = 8'($urandom);
  endtask

  initial begin
    logic [7:0] b [6];
    int pos;
    reset = 1'b1; start = 1'b0; cmd_ready = 1'b0;
    rsp_valid = 1'b0; rsp_ack = 1'b0; rsp_data = 8'h00;
    repeat (3) @(negedge I2C_SCLK);
    check_zero("reset");
    reset = 1'b0;
    @(negedge I2C_SCLK);

    // Clean init followed by the poll gap
    pulse_start();
    chk("busy_start", {31'd0, busy}, 32'd1);
    chk("init_pending", {31'd0, init_done}, 32'd0);
    for (int k = 0; k < 8; k++) plan_init(k, 0, 0);
    chk("init_cmds", plan.size(), 32'd40);
    serve_n(plan.size(), -1);
    chk("init_done", {31'd0, init_done}, 32'd1);
    measure_poll(0, 1'b0);

    // Directed burst with backpressure on the 4th READ, spurious rsp/start in the gap
    b = '{8'h34, 8'h12, 8'hFE, 8'hFF, 8'h00, 8'h01};
    plan_read(b, 0, 0);
    serve_n(plan.size(), 8);
    check_sample(b);
    measure_poll(1, 1'b1);

    // Random bursts, one with a NACK on a random write
    for (int r = 0; r < 3; r++) begin
      rand_bytes(b);
      pos = (r == 1) ? $urandom_range(1, 3) : 0;
      plan_read(b, pos, (pos != 0) ? 1 : 0);
      serve_n(plan.size(), -1);
      chk("no_error_rd", {31'd0, error}, 32'd0);
      check_sample(b);
      measure_poll(1, 1'b0);
    end

    // Reset after the 3rd READ of a burst
    rand_bytes(b);
    plan_read(b, 0, 0);
    serve_n(8, -1);
    plan.delete();
    reset = 1'b1;
    @(negedge I2C_SCLK);
    check_zero("mid_reset");
    reset = 1'b0;
    @(negedge I2C_SCLK);

    // Full init again, single NACK on the register byte of entry 3
    pulse_start();
    for (int k = 0; k < 8; k++) plan_init(k, (k == 3) ? 2 : 0, (k == 3) ? 1 : 0);
    chk("nack_cmds", plan.size(), 32'd44);
    serve_n(plan.size(), -1);
    chk("nack_init_done", {31'd0, init_done}, 32'd1);
    chk("nack_no_error", {31'd0, error}, 32'd0);
    measure_poll(0, 1'b0);
    rand_bytes(b);
    plan_read(b, 0, 0);
    serve_n(plan.size(), -1);
    check_sample(b);
    reset = 1'b1;
    @(negedge I2C_SCLK);
    reset = 1'b0;
    @(negedge I2C_SCLK);

    // Persistent NACK on the device address: three attempts then error
    pulse_start();
    plan_init(0, 1, 3);
    chk("persist_cmds", plan.size(), 32'd9);
    serve_n(plan.size(), -1);
    chk("persist_error", {31'd0, error}, 32'd1);
    chk("persist_busy", {31'd0, busy}, 32'd0);
    chk("persist_init", {31'd0, init_done}, 32'd0);
    repeat (5) @(negedge I2C_SCLK);
    chk("persist_quiet", {31'd0, cmd_valid}, 32'd0);
    chk("persist_sticky", {31'd0, error}, 32'd1);

    // A new start clears the error and reruns init
    pulse_start();
    chk("restart_error", {31'd0, error}, 32'd0);
    chk("restart_busy", {31'd0, busy}, 32'd1);
    for (int k = 0; k < 8; k++) plan_init(k, 0, 0);
    serve_n(plan.size(), -1);
    chk("restart_init", {31'd0, init_done}, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
